zxbus_iodec: RTL and testbench
==============================

# zxbus_iodec

Z80 bus front end of the ZXiznet card: synchronises the asynchronous ZX bus I/O strobes into the card clock and decodes accesses to #81AB/#82AB/#83AB. Feeds the port-register block directly upstream: generates its write strobe, write enable, 2-bit port address and latched write data, plus the data-bus output enable for port reads. All state lives in `clk`; the port-register block latches on the rising edge of `wrstb_n` produced here.

## Interface
- `STB_LEN`, 2: clocks `wrstb_n` is held low per write (legal 1..7)
- `SYNC_STAGES`, 2: flip-flops per strobe synchroniser (legal 2..3)

- `clk`  in  1  card clock; must be ≥ 8× Z80 clock
- `rst`  in  1  synchronous, active-high reset
- `zxa`  in  16  Z80 address bus (async)
- `zxd_in`  in  8  Z80 data bus, input side (async)
- `zxiorq_n`, `zxrd_n`, `zxwr_n`, `zxm1_n`  in  1 each  Z80 control strobes (async)
- `zxd_oe`  out  1  drive card read data onto Z80 data bus
- `wrstb_n`  out  1  write strobe to port registers; data latched on its rising edge
- `wrena`  out  1  write enable qualifying `wrstb_n`
- `addr`  out  2  port select: 01=#81AB, 10=#82AB, 11=#83AB
- `wrdata`  out  8  captured write data

## Operation
- Hit: `zxa[7:0]`==8'hAB, `zxa[15:10]`==6'b100000, `zxa[9:8]`!=2'b00. #80AB is not a hit.
- Strobes pass through `SYNC_STAGES` flops; `zxa`/`zxd_in` registered one clock each cycle (stable long before strobes).
- Qualified cycle: synced `iorq`=0 and `m1`=1. IORQ with M1 low (INTA) ignored.
- FSM states IDLE, WSTB, WREL, RD, WAITEND.
- IDLE→WSTB: qualified, `wr`=0, `rd`=1, hit. Capture `addr`←`zxa[9:8]`, `wrdata`←`zxd_in` (registered copies); `wrstb_n`←0, `wrena`←1.
- WSTB: counter runs `STB_LEN` clocks, then →WREL with `wrstb_n`←1, `wrena` stays 1.
- WREL: one clock; `wrena`←0; →WAITEND.
- IDLE→RD: qualified, `rd`=0, `wr`=1, hit. `addr`←`zxa[9:8]`, `zxd_oe`←1.
- RD: hold `addr`, `zxd_oe`=1 until synced `iorq` or `rd` high; then `zxd_oe`←0, →IDLE.
- WAITEND: stay until synced `iorq`=1 or (`wr`=1 and `rd`=1); →IDLE. Guarantees exactly one write per bus cycle.
- Qualified with `rd`=0 and `wr`=0 simultaneously: no write, no `zxd_oe`; →WAITEND.
- Non-hit or unqualified: stay IDLE, outputs unchanged.
- Strobe released while in WSTB: pulse still completes full `STB_LEN` (data already captured).
- `addr`/`wrdata` change only at IDLE→WSTB/RD; stable throughout strobe and one clock past rising `wrstb_n`.

## Timing
- Reset values: `wrstb_n`=1, `wrena`=0, `addr`=00, `wrdata`=00, `zxd_oe`=0, FSM IDLE, counter 0.
- Reset mid-write: outputs return to reset values at next edge; the port-register block is held in reset by the same reset (`rst_n`=~`rst`), so that `wrstb_n` rise latches nothing.
- Write latency: strobe fall at edge k → synced low after edge k+`SYNC_STAGES`-1 → `wrstb_n`=0 after edge k+`SYNC_STAGES`.
- `wrstb_n` low exactly `STB_LEN` clocks; `wrena`=1 from strobe fall through one clock after `wrstb_n` rise.
- Read: `zxd_oe` rises `SYNC_STAGES`+1 clocks after `rd`/`iorq` fall; falls `SYNC_STAGES`+1 clocks after release.
- Back-to-back I/O cycles: accepted as soon as FSM is IDLE; no cycle lost at ≥ 8× clock ratio.

## Structure
- Package `zxiznet_pkg`: `PORT_LO`=8'hAB, `PORT_HI_TOP`=6'b100000, FSM state enum, port codes 01/10/11.
- One sub-module `zx_sync`: parameterised-depth single-bit synchroniser, reset to 1 (inactive strobe); instantiated for each of the four strobes.

## Test plan
- Write #82AB data 8'h8D, `STB_LEN`=2 → one `wrstb_n` low pulse of 2 clocks, `addr`=10, `wrdata`=8'h8D, `wrena`=1 across rising edge, 0 one clock later.
- Read #83AB → `zxd_oe`=1 at 3 clocks after strobe fall, `addr`=11, `zxd_oe`=0 3 clocks after `rd` release; `wrstb_n` stays 1.
- Write #80AB and #81AC → no `wrstb_n` pulse, no `zxd_oe`, outputs unchanged.
- IORQ+M1 low with `zxa`=16'h81AB, and `rd`=`wr`=0 → no write, no `zxd_oe`.
- Write #81AB held 40 clocks → exactly one pulse; then immediate write #83AB 8'h84 → second pulse, `addr`=11, `wrdata`=8'h84.
- Assert `rst` one clock into WSTB → next edge `wrstb_n`=1, `wrena`=0, `addr`=00, `wrdata`=00; after release, held strobe produces no pulse until a fresh bus cycle.

Source files
------------

// File: rtl/zxbus_iodec_pkg.sv
// ZXiznet ZX-bus I/O decoder: shared constants and types.
// Port map #81AB..#83AB and decoder FSM encoding.
package zxiznet_pkg;

  localparam logic [7:0] PORT_LO     = 8'hAB;
  localparam logic [5:0] PORT_HI_TOP = 6'b100000;

  localparam logic [1:0] PORT_81 = 2'b01;
  localparam logic [1:0] PORT_82 = 2'b10;
  localparam logic [1:0] PORT_83 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WSTB    = 3'd1,
    S_WREL    = 3'd2,
    S_RD      = 3'd3,
    S_WAITEND = 3'd4
  } iodec_state_e;

  // #80AB shares the pattern but is not one of ours
  function automatic logic port_hit(
    input logic [15:0] a
  );
    return (a[7:0] == PORT_LO)
        && (a[15:10] == PORT_HI_TOP)
        && (a[9:8] != 2'b00);
  endfunction

endpackage

// File: rtl/zxbus_iodec_if.sv
// ZXiznet ZX-bus I/O decoder: bus and port-register bundle.
// master drives the Z80 side, slave is the decoder.
interface zxbus_iodec_if;

  logic [15:0] zxa;
  logic [7:0]  zxd_in;
  logic        zxiorq_n;
  logic        zxrd_n;
  logic        zxwr_n;
  logic        zxm1_n;

  logic        zxd_oe;
  logic        wrstb_n;
  logic        wrena;
  logic [1:0]  addr;
  logic [7:0]  wrdata;

  modport master (
    output zxa, zxd_in,
    output zxiorq_n, zxrd_n,
    output zxwr_n, zxm1_n,
    input  zxd_oe, wrstb_n,
    input  wrena, addr, wrdata
  );

  modport slave (
    input  zxa, zxd_in,
    input  zxiorq_n, zxrd_n,
    input  zxwr_n, zxm1_n,
    output zxd_oe, wrstb_n,
    output wrena, addr, wrdata
  );

endinterface

// File: rtl/zxbus_iodec_sync.sv
// ZXiznet ZX-bus I/O decoder: single-bit strobe synchroniser.
// Resets to 1 so an active-low strobe reads as inactive.
module zx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/zxbus_iodec.sv
// ZXiznet ZX-bus I/O decoder: strobe sync, port decode,
// write-strobe generation and read output enable.
module zxbus_iodec
  import zxiznet_pkg::*;
#(
  parameter int STB_LEN     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  zxbus_iodec_if.slave  bus
);

  localparam logic [2:0] IDLE    = S_IDLE;
  localparam logic [2:0] WSTB    = S_WSTB;
  localparam logic [2:0] WREL    = S_WREL;
  localparam logic [2:0] RD      = S_RD;
  localparam logic [2:0] WAITEND = S_WAITEND;

  localparam logic [2:0] CNT_LAST = 3'(STB_LEN - 1);

  logic iorq_s, rd_s, wr_s, m1_s;

  zx_sync #(.STAGES(SYNC_STAGES)) u_sync_iorq (
    .clk(clk), .rst(rst),
    .d_i(bus.zxiorq_n), .q_o(iorq_s)
  );
  zx_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .rst(rst),
    .d_i(bus.zxrd_n), .q_o(rd_s)
  );
  zx_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .rst(rst),
    .d_i(bus.zxwr_n), .q_o(wr_s)
  );
  zx_sync #(.STAGES(SYNC_STAGES)) u_sync_m1 (
    .clk(clk), .rst(rst),
    .d_i(bus.zxm1_n), .q_o(m1_s)
  );

  logic [15:0] zxa_q;
  logic [7:0]  zxd_q;
  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wrstb_n_q, wrstb_n_d;
  logic        wrena_q, wrena_d;
  logic        oe_q, oe_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  wrdata_q, wrdata_d;

  // The synchronisers read inactive right after reset; a strobe
  // still held from before reset must not start a new cycle.
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   armed_q;
  logic                   live;
  logic                   bus_idle;
  logic                   qual;
  logic                   hit;

  assign live     = fill_q[SYNC_STAGES-1];
  assign bus_idle = iorq_s | (wr_s & rd_s);
  assign qual     = ~iorq_s & m1_s & armed_q;
  assign hit      = port_hit(zxa_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wrstb_n_d = wrstb_n_q;
    wrena_d   = wrena_q;
    oe_d      = oe_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    unique case (state_q)
      IDLE: begin
        if (qual) begin
          unique case (1'b1)
            (~wr_s & ~rd_s): begin
              state_d = WAITEND;
            end
            (hit & ~wr_s & rd_s): begin
              state_d   = WSTB;
              cnt_d     = 3'd0;
              addr_d    = zxa_q[9:8];
              wrdata_d  = zxd_q;
              wrstb_n_d = 1'b0;
              wrena_d   = 1'b1;
            end
            (hit & wr_s & ~rd_s): begin
              state_d = RD;
              addr_d  = zxa_q[9:8];
              oe_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      WSTB: begin
        if (cnt_q == CNT_LAST) begin
          state_d   = WREL;
          cnt_d     = 3'd0;
          wrstb_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WREL: begin
        state_d = WAITEND;
        wrena_d = 1'b0;
      end
      RD: begin
        if (iorq_s | rd_s) begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      end
      WAITEND: begin
        if (bus_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zxa_q     <= '0;
      zxd_q     <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      wrstb_n_q <= 1'b1;
      wrena_q   <= 1'b0;
      oe_q      <= 1'b0;
      addr_q    <= '0;
      wrdata_q  <= '0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      zxa_q     <= bus.zxa;
      zxd_q     <= bus.zxd_in;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wrstb_n_q <= wrstb_n_d;
      wrena_q   <= wrena_d;
      oe_q      <= oe_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      if (live && bus_idle) armed_q <= 1'b1;
    end
  end

  assign bus.wrstb_n = wrstb_n_q;
  assign bus.wrena   = wrena_q;
  assign bus.zxd_oe  = oe_q;
  assign bus.addr    = addr_q;
  assign bus.wrdata  = wrdata_q;

endmodule

// File: tb/tb_zxbus_iodec.sv
// Bench for zxbus_iodec: directed bus cycles, write pulses
// checked against a queue of expected port writes.
module tb_zxbus_iodec;
  import zxiznet_pkg::*;

  localparam int STB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  zxbus_iodec_if bus ();

  zxbus_iodec #(
    .STB_LEN(STB),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  pulses = 0;
  int  drop_req = 0;
  int  drop_done = 0;
  int  low_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_stb = 1'b1;
  logic wrena_chk = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_rel();
    bus.zxiorq_n = 1'b1;
    bus.zxrd_n   = 1'b1;
    bus.zxwr_n   = 1'b1;
    bus.zxm1_n   = 1'b1;
  endtask

  task automatic io_wr(input logic [15:0] a,
                       input logic [7:0] d);
    bus.zxa      = a;
    bus.zxd_in   = d;
    bus.zxiorq_n = 1'b0;
    bus.zxwr_n   = 1'b0;
  endtask

  task automatic io_rd(input logic [15:0] a);
    bus.zxa      = a;
    bus.zxiorq_n = 1'b0;
    bus.zxrd_n   = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wrstb"}, 32'(bus.wrstb_n), 1);
    chk({tag, "_wrena"}, 32'(bus.wrena), 0);
    chk({tag, "_addr"}, 32'(bus.addr), 0);
    chk({tag, "_wrdata"}, 32'(bus.wrdata), 0);
    chk({tag, "_oe"}, 32'(bus.zxd_oe), 0);
  endtask

  // Scoreboard side: every rising wrstb_n consumes one expected write
  always @(negedge clk) begin
    wr_t e;
    if (mon_en) begin
      if (wrena_chk) begin
        chk("sb_wrena_after", 32'(bus.wrena), 0);
        wrena_chk = 1'b0;
      end
      if (bus.wrstb_n === 1'b0) begin
        low_cnt++;
        chk("sb_wrena_low", 32'(bus.wrena), 1);
      end else if (prev_stb === 1'b0) begin
        if (drop_req != drop_done) begin
          drop_done++;
        end else begin
          pulses++;
          chk("sb_pulse_expected",
              32'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_addr", 32'(bus.addr), 32'(e.addr));
            chk("sb_data", 32'(bus.wrdata), 32'(e.data));
            chk("sb_len", 32'(low_cnt), STB);
            chk("sb_wrena_rise", 32'(bus.wrena), 1);
            wrena_chk = 1'b1;
          end
        end
        low_cnt = 0;
      end
      prev_stb = bus.wrstb_n;
    end
  end

  initial begin
    bus_rel();
    bus.zxa    = 16'h0000;
    bus.zxd_in = 8'h00;
    rst = 1'b1;
    tick(3);
    chk_reset("rst");
    rst = 1'b0;
    mon_en = 1'b1;
    tick(4);

    // write #82AB, data 8D: latency and pulse shape
    sb_q.push_back(wr_t'{PORT_82, 8'h8D});
    io_wr(16'h82AB, 8'h8D);
    tick(2);
    chk("wr_before_fall", 32'(bus.wrstb_n), 1);
    tick();
    chk("wr_fall", 32'(bus.wrstb_n), 0);
    chk("wr_addr", 32'(bus.addr), 32'(PORT_82));
    chk("wr_data", 32'(bus.wrdata), 32'h8D);
    chk("wr_wrena", 32'(bus.wrena), 1);
    tick();
    chk("wr_low2", 32'(bus.wrstb_n), 0);
    tick();
    chk("wr_rise", 32'(bus.wrstb_n), 1);
    chk("wr_wrena_rise", 32'(bus.wrena), 1);
    tick();
    chk("wr_wrena_off", 32'(bus.wrena), 0);
    tick(4);
    bus_rel();
    tick(4);

    // read #83AB
    io_rd(16'h83AB);
    tick(2);
    chk("rd_oe_early", 32'(bus.zxd_oe), 0);
    tick();
    chk("rd_oe_on", 32'(bus.zxd_oe), 1);
    chk("rd_addr", 32'(bus.addr), 32'(PORT_83));
    tick(6);
    chk("rd_oe_hold", 32'(bus.zxd_oe), 1);
    chk("rd_no_wr", 32'(bus.wrstb_n), 1);
    bus_rel();
    tick(2);
    chk("rd_oe_tail", 32'(bus.zxd_oe), 1);
    tick();
    chk("rd_oe_off", 32'(bus.zxd_oe), 0);
    tick(3);

    // non-hit writes
    io_wr(16'h80AB, 8'h11);
    tick(8);
    chk("nh80_wrstb", 32'(bus.wrstb_n), 1);
    chk("nh80_addr", 32'(bus.addr), 32'(PORT_83));
    chk("nh80_data", 32'(bus.wrdata), 32'h8D);
    bus_rel();
    tick(3);
    io_wr(16'h81AC, 8'h22);
    tick(8);
    chk("nhAC_wrstb", 32'(bus.wrstb_n), 1);
    chk("nhAC_oe", 32'(bus.zxd_oe), 0);
    chk("nhAC_data", 32'(bus.wrdata), 32'h8D);
    bus_rel();
    tick(3);

    // INTA-style cycle, then rd and wr both low
    io_wr(16'h81AB, 8'h33);
    bus.zxm1_n = 1'b0;
    tick(8);
    chk("inta_wrstb", 32'(bus.wrstb_n), 1);
    chk("inta_data", 32'(bus.wrdata), 32'h8D);
    bus_rel();
    tick(3);
    io_wr(16'h81AB, 8'h44);
    bus.zxrd_n = 1'b0;
    tick(8);
    chk("rdwr_wrstb", 32'(bus.wrstb_n), 1);
    chk("rdwr_oe", 32'(bus.zxd_oe), 0);
    chk("rdwr_data", 32'(bus.wrdata), 32'h8D);
    bus_rel();
    tick(3);

    // long write then back-to-back write
    sb_q.push_back(wr_t'{PORT_81, 8'h5A});
    io_wr(16'h81AB, 8'h5A);
    tick(40);
    chk("long_wrstb", 32'(bus.wrstb_n), 1);
    chk("long_wrena", 32'(bus.wrena), 0);
    chk("long_addr", 32'(bus.addr), 32'(PORT_81));
    chk("long_data", 32'(bus.wrdata), 32'h5A);
    bus_rel();
    tick(2);
    sb_q.push_back(wr_t'{PORT_83, 8'h84});
    io_wr(16'h83AB, 8'h84);
    tick(3);
    chk("b2b_fall", 32'(bus.wrstb_n), 0);
    chk("b2b_addr", 32'(bus.addr), 32'(PORT_83));
    chk("b2b_data", 32'(bus.wrdata), 32'h84);
    tick(6);
    bus_rel();
    tick(4);

    // reset one clock into the strobe
    io_wr(16'h82AB, 8'h33);
    tick(3);
    chk("mid_fall", 32'(bus.wrstb_n), 0);
    drop_req++;
    rst = 1'b1;
    tick();
    chk_reset("mid_rst");
    rst = 1'b0;
    tick(10);
    chk("held_no_pulse", 32'(bus.wrstb_n), 1);
    chk("held_wrdata", 32'(bus.wrdata), 0);
    bus_rel();
    tick(4);
    sb_q.push_back(wr_t'{PORT_81, 8'hC3});
    io_wr(16'h81AB, 8'hC3);
    tick(3);
    chk("fresh_fall", 32'(bus.wrstb_n), 0);
    chk("fresh_addr", 32'(bus.addr), 32'(PORT_81));
    chk("fresh_data", 32'(bus.wrdata), 32'hC3);
    tick(6);
    bus_rel();
    tick(6);

    chk("sb_empty", 32'(sb_q.size()), 0);
    chk("pulse_count", 32'(pulses), 4);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
